fetch: RTL

Instruction-fetch stage sitting directly upstream of the decode stage. It owns the PC register and issues one instruction-bus request at a time. It holds each fetched 32-bit instruction with its PC in a single-entry output buffer until decode accepts it. Taken-branch/jump redirects from later stages flush the buffer and squash any in-flight fetch.

---
 rtl/fetch.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues one instruction-bus request at
// a time and holds the fetched word with its PC in a single-entry buffer
// until decode accepts it. Redirects flush the buffer and squash in-flight fetches.
module fetch #(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        buffer_free;

    // Bus request: new requests only when the buffer can take the result and
    // no redirect is pending; an outstanding request is held until data_ok.
    always_comb begin
        buffer_free = !out_valid_q || !stall;
        ireq_valid  = 1'b0;
        ireq_addr   = pc_q;
        unique case (state_q)
            IDLE: begin
                ireq_valid = buffer_free && !redirect_valid;
                ireq_addr  = pc_q;
            end
            BUSY, DROP: begin
                ireq_valid = 1'b1;
                ireq_addr  = req_addr_q;
            end
            default: begin
                ireq_valid = 1'b0;
                ireq_addr  = pc_q;
            end
        endcase
        if (!reset) begin
            ireq_valid = 1'b0;
        end
    end

    // Next-state: redirect beats capture, capture beats consume.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;

        if (out_valid_q && !stall) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (buffer_free) begin
                    if (iresp_data_ok) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = pc_q;
                        out_instr_d = iresp_data;
                        pc_d        = pc_q + 64'd4;
                    end else begin
                        req_addr_d = pc_q;
                        state_d    = BUSY;
                    end
                end
            end
            BUSY: begin
                if (iresp_data_ok) begin
                    state_d = IDLE;
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else begin
                        out_valid_d = 1'b1;
                        out_pc_d    = req_addr_q;
                        out_instr_d = iresp_data;
                        pc_d        = req_addr_q + 64'd4;
                    end
                end else if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (iresp_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect_valid) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= PC_RESET;
            req_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

endmodule
